// File: rtl/fetch_ctrl.sv
// Instruction-fetch sequencer: owns the fetch PC, captures words from a
// combinational instruction memory and hands them to decode over valid/ready.
module fetch_ctrl #(
  parameter int unsigned MEM_BYTES = 32,
  parameter logic [31:0] HALT_CODE = 32'h013900b3
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  output logic [31:0] imem_pc,
  input  logic [31:0] imem_instr,
  output logic        if_valid,
  input  logic        if_ready,
  output logic [31:0] if_instr,
  output logic [31:0] if_pc,
  input  logic        redirect,
  input  logic [31:0] redirect_pc,
  output logic        halted,
  output logic        fault,
  output logic [15:0] fetch_count
);

  localparam logic [31:0] LAST_PC = 32'(MEM_BYTES - 4);

  typedef enum logic [1:0] {
    IDLE,
    FETCH,
    HALT,
    FAULT
  } state_e;

  state_e      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] if_instr_q, if_instr_d;
  logic [31:0] if_pc_q, if_pc_d;
  logic        if_valid_q, if_valid_d;
  logic [15:0] fetch_count_q, fetch_count_d;
  logic        handshake;
  logic        slot_free;

  assign handshake = if_valid_q & if_ready;
  assign slot_free = ~if_valid_q | handshake;

  always_comb begin
    state_d       = state_q;
    pc_d          = pc_q;
    if_instr_d    = if_instr_q;
    if_pc_d       = if_pc_q;
    if_valid_d    = handshake ? 1'b0 : if_valid_q;
    fetch_count_d = fetch_count_q;

    // Accepted words count in every state, even when a redirect flushes the slot.
    if (handshake && (fetch_count_q != '1)) begin
      fetch_count_d = fetch_count_q + 16'd1;
    end

    unique case (state_q)
      IDLE: begin
        pc_d = '0;
        if (start) begin
          state_d = FETCH;
        end
      end
      FETCH: begin
        if (redirect) begin
          if_valid_d = 1'b0;
          if ((redirect_pc[1:0] != 2'b00) || (redirect_pc > LAST_PC)) begin
            state_d = FAULT;
          end else begin
            pc_d = redirect_pc;
          end
        end else if (slot_free) begin
          if (pc_q > LAST_PC) begin
            state_d = FAULT;
          end else if (imem_instr == HALT_CODE) begin
            state_d = HALT;
          end else begin
            if_instr_d = imem_instr;
            if_pc_d    = pc_q;
            if_valid_d = 1'b1;
            pc_d       = pc_q + 32'd4;
          end
        end
      end
      HALT, FAULT: begin
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= IDLE;
      pc_q          <= '0;
      if_instr_q    <= '0;
      if_pc_q       <= '0;
      if_valid_q    <= 1'b0;
      fetch_count_q <= '0;
    end else begin
      state_q       <= state_d;
      pc_q          <= pc_d;
      if_instr_q    <= if_instr_d;
      if_pc_q       <= if_pc_d;
      if_valid_q    <= if_valid_d;
      fetch_count_q <= fetch_count_d;
    end
  end

  assign imem_pc     = pc_q;
  assign if_valid    = if_valid_q;
  assign if_instr    = if_instr_q;
  assign if_pc       = if_pc_q;
  assign halted      = (state_q == HALT);
  assign fault       = (state_q == FAULT);
  assign fetch_count = fetch_count_q;

endmodule

// File: doc/fetch_ctrl.md
# fetch_ctrl

Instruction-fetch sequencer that drives the byte-addressed instruction memory's 32-bit PC input and delivers fetched instruction words to decode over a valid/ready handshake. It owns the architectural fetch PC: sequential increment, redirect from execute, halt on the HCF encoding, and a fault stop on out-of-range or misaligned PCs. It sits between the instruction memory (combinational read) and the decode stage.

## Interface
- MEM_BYTES, 32, instruction memory size in bytes (multiple of 4)
- HALT_CODE, 32'h013900b3, full 32-bit word that stops fetch (HCF)
- clk  input  1  clock, all state on rising edge
- reset  input  1  synchronous, active-high
- start  input  1  begin fetching from PC 0 (sampled in IDLE only)
- imem_pc  output  32  PC to instruction memory (= internal pc register)
- imem_instr  input  32  instruction word returned combinationally for imem_pc
- if_valid  output  1  if_instr/if_pc hold an undelivered instruction
- if_ready  input  1  decode accepts; handshake = if_valid & if_ready
- if_instr  output  32  delivered instruction word
- if_pc  output  32  PC of if_instr
- redirect  input  1  load redirect_pc and flush buffer (FETCH only)
- redirect_pc  input  32  redirect target
- halted  output  1  HALT_CODE reached
- fault  output  1  illegal PC reached
- fetch_count  output  16  delivered-instruction count, saturates at 16'hFFFF

## Operation
- States: IDLE, FETCH, HALT, FAULT. Reset -> IDLE.
- IDLE: pc = 0; start -> FETCH next cycle. redirect ignored.
- FETCH, per cycle, priority order:
  1. redirect: if_valid <= 0 (buffered word flushed, not delivered); if redirect_pc[1:0] != 0 or redirect_pc > MEM_BYTES-4 -> FAULT, pc unchanged; else pc <= redirect_pc.
  2. else if capture slot free (!if_valid or handshake this cycle):
     - pc > MEM_BYTES-4 -> FAULT; if_valid <= 0 if handshake else unchanged.
     - imem_instr == HALT_CODE -> HALT; HCF word never delivered; if_valid <= 0 if handshake.
     - else if_instr <= imem_instr, if_pc <= pc, if_valid <= 1, pc <= pc+4.
  3. else hold all (backpressure); if_instr/if_pc stable while if_valid & !if_ready.
- HALT / FAULT: no further captures; any still-buffered word remains deliverable and clears on handshake; redirect and start ignored; exit only via reset.
- halted = (state == HALT); fault = (state == FAULT); mutually exclusive.
- fetch_count increments on every handshake in any state, including the cycle redirect flushes (the accepted word counts).
- pc arithmetic 32-bit; pc+4 never wraps in practice because the range check fires first.

## Timing
- Reset values: imem_pc 0, if_valid 0, if_instr 0, if_pc 0, halted 0, fault 0, fetch_count 0, state IDLE.
- start at edge N -> FETCH after N; first capture at edge N+1; if_valid high after N+1.
- Throughput one word/cycle with if_ready held high; fetch-to-valid latency 1 cycle.
- Redirect at edge M: if_valid low after M; target word valid after M+1 (one bubble).
- halted/fault assert the cycle after the detecting edge.
- Reset mid-operation: all state returns to reset values at that edge regardless of state or pending handshake; handshake in the reset cycle not counted.

## Test plan
- Default image (word0 0x00940333, word1 0x013900b3), start, if_ready=1 -> one delivery (if_pc 0, if_instr 0x00940333), then halted=1, if_valid=0, fetch_count=1, imem_pc stays 4.
- HALT_CODE=0 with all 8 words present, if_ready=1 -> 8 deliveries PC 0..28 in order, then fault=1 with pc 32, fetch_count=8.
- if_ready low 3 cycles after first capture -> if_instr 0x00940333/if_pc 0 held stable, imem_pc stays 4, fetch_count unchanged until accept.
- Redirect to 8 while word at PC 0 buffered and if_ready=0 -> word flushed undelivered, next delivery if_pc 8, if_instr 0x035a02b3, one bubble.
- Redirect to 6 (misaligned), then separately to 36 (out of range) -> fault=1 next cycle, no further deliveries, halted=0.
- Reset asserted one cycle mid-stream in FETCH -> all outputs at reset values next cycle; start afterwards restarts at PC 0.
